// File: rtl/qc_ldpc_pkg.sv
// -----------------------------------------------------------------------------
// qc_ldpc_pkg
// Shared definitions for the QC-LDPC circulant message memory:
//   - state_t   : controller states (IDLE / LOAD / ALIGN / UNLOAD)
//   - OP_*      : cmd_op encodings (3 is reserved and behaves as a no-op)
//   - clog2_min1: index width helper that never returns 0
// -----------------------------------------------------------------------------
package qc_ldpc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ALIGN  = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'd0;
    localparam logic [1:0] OP_ALIGN  = 2'd1;
    localparam logic [1:0] OP_UNLOAD = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    // Width of an index into a v-entry structure. A 1-entry structure still
    // needs a 1-bit signal, so the result is clamped to at least 1.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/qc_ring_rotator.sv
// -----------------------------------------------------------------------------
// qc_ring_rotator
// Combinational left rotation of a Z-word ring by amt (taken modulo Z):
//   ring_out word i = ring_in word (i + amt) mod Z
// Word i of either ring sits at bits [i*DW +: DW].
// Ports:
//   ring_in  [Z*DW] : packed ring before rotation
//   amt      [SW]   : rotate amount, any value (reduced modulo Z)
//   ring_out [Z*DW] : packed ring after rotation
// -----------------------------------------------------------------------------
module qc_ring_rotator #(
    parameter int DW = 16,
    parameter int Z  = 16,
    parameter int SW = 4
) (
    input  logic [Z*DW-1:0] ring_in,
    input  logic [SW-1:0]   amt,
    output logic [Z*DW-1:0] ring_out
);

    localparam int unsigned ZU = Z;

    always_comb begin
        int unsigned a;
        int unsigned src;
        a        = 32'(amt) % ZU;
        ring_out = '0;
        for (int unsigned i = 0; i < ZU; i++) begin
            src = (i + a) % ZU;
            ring_out[i*DW +: DW] = ring_in[src*DW +: DW];
        end
    end

endmodule

// File: rtl/qc_circ_msg_mem.sv
// -----------------------------------------------------------------------------
// qc_circ_msg_mem
// Circulant message memory: one Z-word ring of DW-bit messages supporting
// serial load, cyclic-shift alignment, P-lane rotating sweeps and serial unload.
//
// Build option: define BARREL_ALIGN_EN to perform ALIGN in one cycle through
// qc_ring_rotator; otherwise ALIGN rotates one word per cycle (max(shift,1)
// cycles). Final ring contents are the same in both builds.
//
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   cmd_valid/ready      : command handshake, cmd_op / cmd_shift sampled on accept
//   ld_valid, ld_data    : serial load word (LOAD state only)
//   sw_rd, sw_wr         : sweep read / write beat (IDLE only)
//   sw_wdata             : sweep write lanes, lane k at [k*DW +: DW]
//   sw_rdata, sw_rvalid  : registered sweep read lanes
//   sw_wrap              : pulse when Z/P beats return the ring to its alignment
//   ul_data, ul_valid    : registered serial unload word
//   busy                 : controller not in IDLE
//   dbg_state            : current controller state (state_t encoding)
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_ready is high exactly in IDLE and does not depend on cmd_valid. The
// ld/sw/ul strobes are single-cycle qualifiers with no back-pressure.
// -----------------------------------------------------------------------------
module qc_circ_msg_mem
    import qc_ldpc_pkg::*;
#(
    parameter int DW = 16,
    parameter int Z  = 16,
    parameter int P  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [clog2_min1(Z)-1:0] cmd_shift,
    input  logic                     ld_valid,
    input  logic [DW-1:0]            ld_data,
    input  logic                     sw_rd,
    input  logic                     sw_wr,
    input  logic [P*DW-1:0]          sw_wdata,
    output logic [P*DW-1:0]          sw_rdata,
    output logic                     sw_rvalid,
    output logic                     sw_wrap,
    output logic [DW-1:0]            ul_data,
    output logic                     ul_valid,
    output logic                     busy,
    output logic [1:0]               dbg_state
);

    localparam int          SW    = clog2_min1(Z);
    localparam int          NB    = Z / P;
    localparam int          BW    = clog2_min1(NB);
    localparam int unsigned ZU    = Z;
    localparam logic [SW-1:0] LAST  = SW'(Z - 1);
    localparam logic [BW-1:0] LASTB = BW'(NB - 1);

    if (Z < 2 || (Z % P) != 0) begin : g_bad_cfg
        $error("qc_circ_msg_mem: Z must be >= 2 and divisible by P");
    end

    state_t        state, state_nxt;
    logic [DW-1:0] ring [Z];
    logic [SW-1:0] cnt;        // load / unload word index
    logic [SW-1:0] rem;        // remaining ALIGN rotation
    logic [BW-1:0] bcnt;       // sweep beat index modulo Z/P
    logic [SW-1:0] shift_mod;
    logic          acc;
    logic          beat;

    assign acc       = cmd_valid && (state == ST_IDLE);
    // A command in the same cycle takes priority and drops the sweep beat.
    assign beat      = (state == ST_IDLE) && !cmd_valid && (sw_rd || sw_wr);
    assign shift_mod = SW'(32'(cmd_shift) % ZU);

`ifdef BARREL_ALIGN_EN
    logic [Z*DW-1:0] ring_flat;
    logic [Z*DW-1:0] rot_flat;

    always_comb begin
        ring_flat = '0;
        for (int i = 0; i < Z; i++) ring_flat[i*DW +: DW] = ring[i];
    end

    qc_ring_rotator #(.DW(DW), .Z(Z), .SW(SW)) u_rot (
        .ring_in  (ring_flat),
        .amt      (rem),
        .ring_out (rot_flat)
    );
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD:   state_nxt = ST_LOAD;
                        OP_ALIGN:  state_nxt = ST_ALIGN;
                        OP_UNLOAD: state_nxt = ST_UNLOAD;
                        default:   state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (ld_valid && cnt == LAST) state_nxt = ST_IDLE;
            end
            ST_ALIGN: begin
`ifdef BARREL_ALIGN_EN
                state_nxt = ST_IDLE;
`else
                // rem==0 still costs the one ALIGN cycle, without rotating.
                if (rem <= SW'(1)) state_nxt = ST_IDLE;
`endif
            end
            ST_UNLOAD: begin
                if (cnt == LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        cmd_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        dbg_state = state;
    end

    // Ring and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Z; i++) ring[i] <= '0;
            cnt       <= '0;
            rem       <= '0;
            bcnt      <= '0;
            sw_rdata  <= '0;
            sw_rvalid <= 1'b0;
            sw_wrap   <= 1'b0;
            ul_data   <= '0;
            ul_valid  <= 1'b0;
        end else begin
            sw_rdata  <= '0;
            sw_rvalid <= 1'b0;
            sw_wrap   <= 1'b0;
            ul_data   <= '0;
            ul_valid  <= 1'b0;

            if (acc) begin
                cnt <= '0;
                if (cmd_op == OP_LOAD || cmd_op == OP_ALIGN) bcnt <= '0;
                if (cmd_op == OP_ALIGN) rem <= shift_mod;
            end else if (beat) begin
                for (int i = 0; i < Z - P; i++) ring[i] <= ring[i+P];
                for (int k = 0; k < P; k++)
                    ring[Z-P+k] <= sw_wr ? sw_wdata[k*DW +: DW] : ring[k];
                if (sw_rd) begin
                    sw_rvalid <= 1'b1;
                    for (int k = 0; k < P; k++) sw_rdata[k*DW +: DW] <= ring[k];
                end
                sw_wrap <= (bcnt == LASTB);
                bcnt    <= (bcnt == LASTB) ? '0 : bcnt + BW'(1);
            end

            case (state)
                ST_LOAD: begin
                    if (ld_valid) begin
                        ring[cnt] <= ld_data;
                        cnt       <= cnt + SW'(1);
                    end
                end
                ST_ALIGN: begin
`ifdef BARREL_ALIGN_EN
                    for (int i = 0; i < Z; i++) ring[i] <= rot_flat[i*DW +: DW];
                    rem <= '0;
`else
                    if (rem != '0) begin
                        for (int i = 0; i < Z; i++) ring[i] <= ring[(i+1) % Z];
                        rem <= rem - SW'(1);
                    end
`endif
                end
                ST_UNLOAD: begin
                    ul_valid <= 1'b1;
                    ul_data  <= ring[cnt];
                    cnt      <= cnt + SW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
